// File: rtl/fifo_word_serializer.sv
// -----------------------------------------------------------------------------
// fifo_word_serializer
//
// Drain stage placed directly after a FIFO with registered read data. Pops one
// DATA_WIDTH-bit word at a time and emits it as BEATS = DATA_WIDTH/OUT_WIDTH
// beats of OUT_WIDTH bits on a valid/ready output, least-significant beat
// first. A popped word is always emitted in full. enable_i only decides
// whether a *new* word may be started, so the owner can stall draining at a
// word boundary. Completed words are counted in a 16-bit wrapping counter.
//
// DATA_WIDTH must be an integer multiple of OUT_WIDTH, giving at least 2 beats.
//
// Ports:
//   clk             in   clock
//   reset_n         in   asynchronous active-low reset
//   enable_i        in   permit starting a new word
//   fifo_empty_i    in   FIFO empty flag
//   fifo_rd_data_i  in   FIFO read data, valid the cycle after a pop
//   fifo_pop_o      out  FIFO pop request (combinational, never while empty)
//   out_valid_o     out  beat valid
//   out_data_o      out  beat data
//   out_last_o      out  final beat of the current word
//   out_ready_i     in   downstream accept
//   busy_o          out  FSM is not IDLE
//   word_count_o    out  number of completed words (wraps)
// -----------------------------------------------------------------------------
module fifo_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_pop_o,
  output logic                  out_valid_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic [15:0]           word_count_o
);

  localparam int BEATS     = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_WIDTH = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]            word_count_q, word_count_d;

  logic can_start;
  logic last_beat;
  logic beat_hs;

  // A new word may only be started when allowed and the FIFO has data; this
  // single term gates every pop, so a pop can never hit an empty FIFO.
  assign can_start = enable_i && !fifo_empty_i;
  assign last_beat = (beat_cnt_q == CNT_WIDTH'(BEATS - 1));
  assign beat_hs   = (state_q == SEND) && out_ready_i;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (can_start) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND: begin
        // Chain straight into the next word's FETCH when possible, so the
        // only bubble between words is the FETCH cycle itself.
        if (out_ready_i && last_beat) state_d = can_start ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_pop_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: fifo_pop_o = can_start;
      SEND: begin
        out_valid_o = 1'b1;
        out_data_o  = shift_q[OUT_WIDTH-1:0];
        out_last_o  = last_beat;
        fifo_pop_o  = out_ready_i && last_beat && can_start;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign word_count_o = word_count_q;

  // Datapath next-state: load in FETCH, shift on every non-final accepted
  // beat. The register holds while stalled, which keeps out_data_o stable.
  always_comb begin
    shift_d      = shift_q;
    beat_cnt_d   = beat_cnt_q;
    word_count_d = word_count_q;
    if (state_q == FETCH) begin
      shift_d    = fifo_rd_data_i;
      beat_cnt_d = '0;
    end else if (beat_hs) begin
      if (last_beat) begin
        word_count_d = word_count_q + 16'd1;
      end else begin
        shift_d    = shift_q >> OUT_WIDTH;
        beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q      <= '0;
      beat_cnt_q   <= '0;
      word_count_q <= '0;
    end else begin
      shift_q      <= shift_d;
      beat_cnt_q   <= beat_cnt_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
module tb_fifo_word_serializer;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int BEATS = DW / OW;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] rd_data;
  logic          fifo_pop;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic [15:0]   wc;

  fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enable),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (rd_data),
    .fifo_pop_o     (fifo_pop),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_last_o     (out_last),
    .out_ready_i    (out_ready),
    .busy_o         (busy),
    .word_count_o   (wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [DW-1:0]           word;
    int                      stall_at;
    int                      stall_len;
    logic [BEATS-1:0][OW-1:0] exp_b;
  } vec_t;

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [DW-1:0] fifo_q[$];
  exp_t        exp_q[$];
  int          pop_log[$];
  beat_t       beat_log[$];
  logic [15:0] model_cnt;
  int          stall_cnt;
  logic        prev_stall;
  logic [OW-1:0] prev_d;
  logic        prev_l;
  logic [DW-1:0] popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // FIFO with registered read data; every pop queues the word's beats,
  // LSB beat first, as the expected output stream.
  task automatic fifo_proc();
    forever begin
      @(posedge clk);
      if (reset_n && fifo_pop) begin
        pop_log.push_back(cyc);
        if (fifo_q.size() == 0) begin
          chk("pop_underflow", {31'd0, fifo_empty}, 32'd0);
        end else begin
          popped = fifo_q.pop_front();
          rd_data <= popped;
          for (int b = 0; b < BEATS; b++)
            exp_q.push_back('{popped[b*OW +: OW], (b == BEATS - 1)});
        end
      end
      fifo_empty <= (fifo_q.size() == 0);
      cyc = cyc + 1;
    end
  endtask

  task automatic monitor_proc();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("word_count", {16'd0, wc}, {16'd0, model_cnt});
        if (fifo_pop) chk("pop_when_empty", {31'd0, fifo_empty}, 32'd0);
        if (prev_stall) begin
          chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
          chk("stall_data_held", {24'd0, out_data}, {24'd0, prev_d});
          chk("stall_last_held", {31'd0, out_last}, {31'd0, prev_l});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("beat_without_pop", {31'd0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", {24'd0, out_data}, {24'd0, e.d});
            chk("beat_last", {31'd0, out_last}, {31'd0, e.l});
            if (e.l) model_cnt = model_cnt + 16'd1;
          end
          beat_log.push_back('{cyc, out_data, out_last});
        end
        if (out_valid && !out_ready) stall_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_l     = out_last;
      end
    end
  endtask

  // Drive ready (low for stall_len cycles while beat index stall_at is shown)
  // until n more beats have been accepted or the cycle budget runs out.
  task automatic run_beats(input int n, input int stall_at, input int stall_len,
                           input int max_cyc, input string name);
    int left;
    int base;
    bit ok;
    left = stall_len;
    base = beat_log.size();
    ok   = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (out_valid && (beat_log.size() - base) == stall_at && left > 0) begin
        out_ready = 1'b0;
        left--;
      end else begin
        out_ready = 1'b1;
      end
      step();
      if (beat_log.size() - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    chk({name, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    beat_log.delete();
    stall_cnt = 0;
  endtask

  vec_t vecs[4];
  int   dir_words;
  int   c0;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    model_cnt  = 16'd0;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    popped     = '0;
    dir_words  = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    rd_data    = '0;
    out_ready  = 1'b0;

    vecs[0] = '{32'hDDCCBBAA, -1, 0, {8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    vecs[1] = '{32'hDDCCBBAA,  1, 3, {8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    vecs[2] = '{32'h80FF0001, -1, 0, {8'h80, 8'hFF, 8'h00, 8'h01}};
    vecs[3] = '{32'h12345678,  3, 1, {8'h12, 8'h34, 8'h56, 8'h78}};

    fork
      fifo_proc();
      monitor_proc();
      begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    step();
    step();
    chk("rst_pop",   {31'd0, fifo_pop},  32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_wc",    {16'd0, wc},        32'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();

    // Table-driven single words (basic, back-pressure, patterns)
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      c0 = cyc;
      fifo_push(vecs[v].word);
      enable = 1'b1;
      run_beats(BEATS, vecs[v].stall_at, vecs[v].stall_len, 30, $sformatf("vec%0d", v));
      step();
      dir_words++;
      chk($sformatf("vec%0d_pops", v), pop_log.size(), 32'd1);
      if (pop_log.size() >= 1 && beat_log.size() >= BEATS) begin
        chk($sformatf("vec%0d_pop_cyc", v), pop_log[0], c0);
        chk($sformatf("vec%0d_first_beat_cyc", v), beat_log[0].cyc, pop_log[0] + 2);
        chk($sformatf("vec%0d_last_beat_cyc", v), beat_log[BEATS-1].cyc,
            pop_log[0] + 1 + BEATS + (vecs[v].stall_len));
        for (int b = 0; b < BEATS; b++) begin
          chk($sformatf("vec%0d_b%0d_data", v, b), {24'd0, beat_log[b].d}, {24'd0, vecs[v].exp_b[b]});
          chk($sformatf("vec%0d_b%0d_last", v, b), {31'd0, beat_log[b].l}, (b == BEATS - 1) ? 32'd1 : 32'd0);
        end
      end
      chk($sformatf("vec%0d_stalls", v), stall_cnt, vecs[v].stall_len);
      chk($sformatf("vec%0d_wc", v), {16'd0, wc}, dir_words);
    end

    // Back-to-back words
    clear_logs();
    fifo_push(32'h04030201);
    fifo_push(32'h08070605);
    enable = 1'b1;
    run_beats(2 * BEATS, -1, 0, 40, "b2b");
    step();
    dir_words += 2;
    chk("b2b_pops", pop_log.size(), 32'd2);
    if (pop_log.size() >= 2 && beat_log.size() >= 2 * BEATS) begin
      chk("b2b_pop2_with_last", pop_log[1], beat_log[BEATS-1].cyc);
      chk("b2b_one_bubble", beat_log[BEATS].cyc, beat_log[BEATS-1].cyc + 2);
      for (int b = 0; b < 2 * BEATS; b++)
        chk($sformatf("b2b_b%0d", b), {24'd0, beat_log[b].d}, b + 1);
    end
    chk("b2b_wc", {16'd0, wc}, dir_words);

    // Enable drop during beat 1 with a second word queued
    clear_logs();
    fifo_push(32'hA4A3A2A1);
    fifo_push(32'hB4B3B2B1);
    enable = 1'b1;
    for (int k = 0; k < 10 && !out_valid; k++) step();
    enable = 1'b0;
    run_beats(BEATS, -1, 0, 20, "endrop");
    for (int k = 0; k < 4; k++) step();
    chk("endrop_pops", pop_log.size(), 32'd1);
    chk("endrop_busy", {31'd0, busy}, 32'd0);
    if (beat_log.size() >= BEATS) begin
      chk("endrop_b0", {24'd0, beat_log[0].d}, 32'hA1);
      chk("endrop_b3", {24'd0, beat_log[BEATS-1].d}, 32'hA4);
    end
    enable = 1'b1;
    run_beats(BEATS, -1, 0, 20, "reenable");
    step();
    dir_words += 2;
    chk("reenable_pops", pop_log.size(), 32'd2);
    if (beat_log.size() >= 2 * BEATS) begin
      chk("reenable_b0", {24'd0, beat_log[BEATS].d}, 32'hB1);
      chk("reenable_b3", {24'd0, beat_log[2*BEATS-1].d}, 32'hB4);
    end
    chk("reenable_wc", {16'd0, wc}, dir_words);

    // Empty FIFO: enabled but nothing to pop
    clear_logs();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("empty_pops", pop_log.size(), 32'd0);
    chk("empty_busy", {31'd0, busy}, 32'd0);

    // Word counter wrap
    force dut.word_count_q = 16'hFFFF;
    model_cnt = 16'hFFFF;
    step();
    release dut.word_count_q;
    step();
    chk("wrap_preload", {16'd0, wc}, 32'h0000FFFF);
    clear_logs();
    fifo_push(32'h5A5A5A5A);
    run_beats(BEATS, -1, 0, 20, "wrap");
    step();
    chk("wrap_wc", {16'd0, wc}, 32'd0);

    // Reset in the middle of a word
    clear_logs();
    fifo_push(32'h44332211);
    run_beats(2, -1, 0, 20, "midrst");
    reset_n = 1'b0;
    #1;
    chk("midrst_pop",   {31'd0, fifo_pop},  32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data",  {24'd0, out_data},  32'd0);
    chk("midrst_last",  {31'd0, out_last},  32'd0);
    chk("midrst_busy",  {31'd0, busy},      32'd0);
    chk("midrst_wc",    {16'd0, wc},        32'd0);
    exp_q.delete();
    model_cnt = 16'd0;
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    clear_logs();
    fifo_push(32'h88776655);
    run_beats(BEATS, -1, 0, 20, "postrst");
    for (int k = 0; k < 4; k++) step();
    chk("postrst_beats", beat_log.size(), BEATS);
    if (beat_log.size() >= BEATS) begin
      chk("postrst_b0", {24'd0, beat_log[0].d}, 32'h55);
      chk("postrst_b3", {24'd0, beat_log[BEATS-1].d}, 32'h88);
    end
    chk("postrst_wc", {16'd0, wc}, 32'd1);

    // Randomized traffic against the scoreboard
    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_push($urandom);
      step();
    end
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && (fifo_q.size() != 0 || busy); k++) step();
    step();
    chk("drain_fifo_empty", fifo_q.size(), 32'd0);
    chk("drain_exp_empty", exp_q.size(), 32'd0);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Drain stage that sits directly downstream of the generic `fifo`. It pops DATA_WIDTH-bit words from the FIFO's read side and serializes each word into OUT_WIDTH-bit beats on a valid/ready output, least-significant beat first. The block also counts completed words, and an enable lets the owner stall draining cleanly at a word boundary.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width.
- BEATS (localparam), DATA_WIDTH/OUT_WIDTH, beats per word; must be ≥ 2.
- CNT_WIDTH (localparam), $clog2(BEATS), beat counter width.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset.
- enable_i  input  1  permits starting a new word; sampled only in IDLE and at the last-beat handshake.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_data_i  input  DATA_WIDTH  FIFO registered read data; valid the cycle after a pop.
- fifo_pop_o  output  1  pop request to the FIFO; combinational, asserted only when fifo_empty_i=0.
- out_valid_o  output  1  beat valid.
- out_data_o  output  OUT_WIDTH  beat data.
- out_last_o  output  1  high with the final beat of a word.
- out_ready_i  input  1  downstream accept.
- busy_o  output  1  high in any state other than IDLE.
- word_count_o  output  16  completed words; wraps 0xFFFF→0x0000.

## Operation
- FSM states are IDLE, FETCH and SEND. All registers reset to 0 and the state resets to IDLE.
- IDLE:
  - When enable_i=1 and fifo_empty_i=0: fifo_pop_o=1, next state FETCH.
  - Otherwise: fifo_pop_o=0, stay in IDLE.
- FETCH (exactly one cycle):
  - Load the shift register from fifo_rd_data_i and clear beat_cnt. Next state SEND.
  - fifo_pop_o=0 and out_valid_o=0 in this state.
- SEND:
  - out_valid_o=1, out_data_o = shift_reg[OUT_WIDTH-1:0], out_last_o = (beat_cnt == BEATS-1).
  - Handshake on a non-final beat: shift the register right by OUT_WIDTH and increment beat_cnt.
  - Handshake on the final beat: word_count increments. If enable_i=1 and fifo_empty_i=0, then fifo_pop_o=1 in the same cycle and next state FETCH; otherwise next state IDLE.
  - No handshake (out_ready_i=0): hold the state, the data and out_last_o unchanged.
- Once a word has been popped, it is always fully emitted. Deasserting enable_i never truncates a word.
- fifo_pop_o must never assert when fifo_empty_i=1, so every pop is a valid FIFO pop.
- The shift register is DATA_WIDTH bits and zero-fills from the MSB side as it shifts.

## Timing
- Reset values: fifo_pop_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, word_count_o=0.
- Reset is asynchronous. Asserting it mid-word discards the partial word, with no further beats and no count increment.
- Pop-to-first-beat latency:
  - Pop asserted in cycle T.
  - FETCH in T+1.
  - First beat valid in T+2.
- Throughput is BEATS+1 cycles per word with out_ready_i held high. FETCH is the single bubble cycle between words.
- out_valid_o is held stable until accepted. out_data_o does not change while valid and not ready.
- word_count_o updates on the clock edge that completes the final-beat handshake.
- busy_o is registered from the state, so it rises in the FETCH cycle.

## Test plan
- Basic word: reset, FIFO holds 0xDDCCBBAA, enable_i=1, ready=1.
  - Expect pop in cycle 1.
  - Expect beats 0xAA, 0xBB, 0xCC, 0xDD in cycles 3–6, with out_last_o high only with 0xDD.
  - Expect word_count_o=1 afterwards.
- Back-pressure: same word with out_ready_i low for 3 cycles on beat 2.
  - Expect 0xBB held stable with valid high for those 3 cycles.
  - Expect no extra pop and order preserved.
- Back-to-back words: FIFO holds 0x04030201 then 0x08070605, ready=1.
  - Expect the second pop coincident with the 0x04 handshake.
  - Expect exactly one FETCH bubble between words, 8 beats total, word_count_o=2.
- Enable drop mid-word: clear enable_i during beat 1 with a second word queued.
  - Expect the current word to finish all 4 beats.
  - Expect no pop, return to IDLE with busy_o=0.
  - On re-enable, expect the next word to be popped.
- Empty and wrap: with fifo_empty_i=1, expect fifo_pop_o never asserted. Preload word_count to 0xFFFF via 65535 words or force, send one word, and expect word_count_o=0x0000.
- Reset mid-word: assert reset_n=0 after beat 2.
  - Expect all outputs to be 0 immediately (asynchronous).
  - After release, expect the FSM in IDLE and the next word to start from beat 0.
